instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 232 +++++++++++++++++++++++
 tb/tb_instruction_fetch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch unit with a single outstanding request and a 2-entry buffer
//
// Fetches 32-bit instruction words from memory one request at a time and
// queues them, with their addresses, for the decode stage.
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   reset        in   asynchronous active-high reset
//   mem_req      out  read request to instruction memory
//   mem_addr     out  word-aligned fetch address, held until mem_ack
//   mem_ack      in   mem_rdata is valid this cycle (ignored when mem_req=0)
//   mem_rdata    in   fetched instruction word
//   redirect     in   control-flow change from downstream
//   redirect_pc  in   new fetch address (low two bits ignored)
//   inst_valid   out  inst/inst_pc hold a buffered instruction
//   inst_ready   in   decode accepts the head instruction
//   inst         out  head instruction word
//   inst_pc      out  address of the head instruction
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam logic [1:0] DEPTH = BUF_DEPTH[1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // Reset leaves the FSM in REQ, but the request must not be visible until
    // the first clock edge after reset is released; live gates mem_req.
    logic        live;

    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic [31:0] pend_pc;
    logic [31:0] pend_pc_next;
    logic [31:0] target_pc;

    logic [31:0] fifo_data [0:1];
    logic [31:0] fifo_pc   [0:1];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [1:0]  count_next;

    logic        eff_ack;
    logic        push;
    logic        pop;
    logic        space;
    logic        unused_pc_bits;

    assign target_pc      = {redirect_pc[31:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];

    // An ack only means something while our request is visible.
    assign eff_ack = mem_ack & mem_req;

    assign inst_valid = (count != 2'd0);
    assign pop        = inst_valid & inst_ready;
    assign push       = (state == REQ) & eff_ack & ~redirect;

    // Occupancy after this cycle's push/pop; a redirect empties the buffer
    // even if a pop is also happening (the pop itself still completes).
    always_comb begin
        count_next = count;
        if (redirect) begin
            count_next = 2'd0;
        end else begin
            count_next = count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign space = (count_next < DEPTH);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= REQ;
            live  <= 1'b0;
        end else begin
            state <= state_next;
            live  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (redirect || space) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    // Without the ack the request is still in flight and
                    // its data has to be thrown away when it returns.
                    state_next = eff_ack ? REQ : DROP;
                end else if (eff_ack) begin
                    state_next = space ? REQ : IDLE;
                end
            end
            DROP: begin
                if (eff_ack) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_req = 1'b0;
        if (live && (state == REQ || state == DROP)) begin
            mem_req = 1'b1;
        end
    end

    assign mem_addr = fetch_pc;

    // ------------------------------------------------------------------
    // Fetch address and pending redirect target
    // ------------------------------------------------------------------
    // fetch_pc is the address on the bus; it only changes once the current
    // request has been acked (or when nothing is outstanding), so mem_addr is
    // stable for the whole request. A redirect that arrives while a request
    // is in flight is parked in pend_pc until the stale ack comes back.
    always_comb begin
        fetch_pc_next = fetch_pc;
        pend_pc_next  = pend_pc;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_next = target_pc;
                end
            end
            REQ: begin
                if (redirect) begin
                    if (eff_ack) begin
                        fetch_pc_next = target_pc;
                    end else begin
                        pend_pc_next = target_pc;
                    end
                end else if (eff_ack) begin
                    fetch_pc_next = fetch_pc + 32'd4;
                end
            end
            DROP: begin
                if (eff_ack) begin
                    fetch_pc_next = redirect ? target_pc : pend_pc;
                end else if (redirect) begin
                    pend_pc_next = target_pc;
                end
            end
            default: begin
                fetch_pc_next = fetch_pc;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            pend_pc  <= RESET_PC;
        end else begin
            fetch_pc <= fetch_pc_next;
            pend_pc  <= pend_pc_next;
        end
    end

    // ------------------------------------------------------------------
    // Instruction buffer (2-entry FIFO)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_data[0] <= 32'd0;
            fifo_data[1] <= 32'd0;
            fifo_pc[0]   <= 32'd0;
            fifo_pc[1]   <= 32'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
        end else begin
            count <= count_next;
            if (redirect) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    fifo_data[wr_ptr] <= mem_rdata;
                    fifo_pc[wr_ptr]   <= fetch_pc;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end
        end
    end

    // Empty buffer presents zeros so reset and flush give clean outputs.
    assign inst    = inst_valid ? fifo_data[rd_ptr] : 32'd0;
    assign inst_pc = inst_valid ? fifo_pc[rd_ptr]   : 32'd0;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int tests;
    int fails;

    instruction_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: one flag for "a request is on the bus", one for
    // "that request's data is stale", and a queue holding buffered words.
    typedef struct {
        logic [31:0] d;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    bit          m_busy;
    bit          m_stale;
    logic [31:0] m_addr;
    logic [31:0] m_next;
    logic [31:0] m_pend;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy  = 1'b1;
        m_stale = 1'b0;
        m_addr  = RST_PC;
        m_next  = RST_PC;
        m_pend  = RST_PC;
    endtask

    task automatic model_update(input bit a, input bit r, input bit rd,
                                input logic [31:0] rp, input logic [31:0] rdata);
        bit          ack;
        logic [31:0] tgt;
        ack = a && m_busy;
        tgt = rp & 32'hFFFF_FFFC;
        if (q.size() > 0 && r) void'(q.pop_front());
        if (rd) begin
            q.delete();
            if (m_busy && !ack) begin
                m_stale = 1'b1;
                m_pend  = tgt;
            end else begin
                m_busy  = 1'b0;
                m_stale = 1'b0;
                m_next  = tgt;
            end
        end else if (ack) begin
            if (m_stale) begin
                m_next  = m_pend;
                m_stale = 1'b0;
            end else begin
                q.push_back('{d: rdata, pc: m_addr});
                m_next = m_addr + 32'd4;
            end
            m_busy = 1'b0;
        end
        if (!m_busy && q.size() < 2) begin
            m_busy = 1'b1;
            m_addr = m_next;
        end
    endtask

    task automatic check_outputs();
        chk("mem_req", {31'd0, mem_req}, {31'd0, m_busy});
        if (m_busy) chk("mem_addr", mem_addr, m_addr);
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, (q.size() > 0)});
        if (q.size() > 0) begin
            chk("inst", inst, q[0].d);
            chk("inst_pc", inst_pc, q[0].pc);
        end
    endtask

    // One clock cycle: compare, drive, clock, advance the model.
    task automatic step(input bit a, input bit r, input bit rd, input logic [31:0] rp);
        logic [31:0] rdata;
        check_outputs();
        rdata       = memword(m_addr);
        mem_ack     = a && m_busy;
        mem_rdata   = rdata;
        inst_ready  = r;
        redirect    = rd;
        redirect_pc = rp;
        @(posedge clk);
        model_update(a, r, rd, rp, rdata);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        mem_ack     = 1'b0;
        mem_rdata   = 32'd0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_mem_addr", mem_addr, RST_PC);
        @(posedge clk);
        #1;
        chk("rst_hold_mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        model_reset();
        chk("start_mem_req", {31'd0, mem_req}, 32'd1);
        chk("start_mem_addr", mem_addr, RST_PC);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        #2;

        // Streaming: ack every cycle, always ready
        do_reset();
        step(1, 1, 0, 0);
        chk("stream_lat_valid", {31'd0, inst_valid}, 32'd1);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("stream_addr", mem_addr, 32'd12);
        chk("stream_inst_pc", inst_pc, 32'd8);
        step(1, 1, 0, 0);
        chk("stream_valid", {31'd0, inst_valid}, 32'd1);

        // Backpressure
        do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("bp_idle", {31'd0, mem_req}, 32'd0);
        chk("bp_inst_pc", inst_pc, 32'd0);
        chk("bp_inst", inst, memword(32'd0));
        step(0, 0, 0, 0);
        chk("bp_hold_inst_pc", inst_pc, 32'd0);
        step(0, 1, 0, 0);
        chk("bp_resume_req", {31'd0, mem_req}, 32'd1);
        chk("bp_resume_addr", mem_addr, 32'd8);

        // Redirect while a request is outstanding
        do_reset();
        repeat (4) step(1, 1, 0, 0);
        chk("rd_pre_addr", mem_addr, 32'h10);
        step(0, 1, 1, 32'h103);
        chk("rd_hold_addr", mem_addr, 32'h10);
        chk("rd_flush", {31'd0, inst_valid}, 32'd0);
        step(1, 1, 0, 0);
        chk("rd_new_addr", mem_addr, 32'h100);
        chk("rd_discard", {31'd0, inst_valid}, 32'd0);
        step(1, 0, 0, 0);
        chk("rd_first_pc", inst_pc, 32'h100);

        // Redirect with ack and pop in the same cycle
        step(1, 1, 1, 32'h200);
        chk("sim_valid", {31'd0, inst_valid}, 32'd0);
        chk("sim_addr", mem_addr, 32'h200);

        // Address wrap
        step(1, 0, 1, 32'hFFFF_FFFC);
        chk("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        chk("wrap_addr1", mem_addr, 32'h0000_0000);
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);

        // Reset in the middle of a dropped request
        step(0, 0, 1, 32'h40);
        chk("drop_req", {31'd0, mem_req}, 32'd1);
        step(0, 0, 1, 32'h80);
        do_reset();
        step(1, 1, 0, 0);
        chk("post_rst_inst_pc", inst_pc, RST_PC);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bit          a;
            bit          r;
            bit          rd;
            logic [31:0] rp;
            a  = ($urandom_range(0, 9) < 7);
            r  = ($urandom_range(0, 9) < 6);
            rd = ($urandom_range(0, 99) < 6);
            rp = $urandom;
            if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hF);
            step(a, r, rd, rp);
        end
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
